// File: rtl/riscv_hwlp_pkg.sv
// Shared definitions for the hardware-loop register file: write-enable bit
// positions, loop count and the address/counter word type.
package riscv_hwlp_pkg;

    localparam int HWLP_WE_START = 0;
    localparam int HWLP_WE_END   = 1;
    localparam int HWLP_WE_CNT   = 2;

    localparam int HWLP_N_REGS   = 2;

    typedef logic [31:0] hwlp_word_t;

    // Counter decrement that sticks at zero instead of wrapping to all-ones.
    function automatic hwlp_word_t hwlp_sat_dec(input hwlp_word_t value);
        hwlp_word_t result;
        if (value == '0) begin
            result = '0;
        end else begin
            result = value - hwlp_word_t'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/riscv_hwloop_slot.sv
// One hardware loop: start/end/counter registers plus the in-flight decrement
// bit. Write enables arrive already qualified by loop id from the parent.
module riscv_hwloop_slot
    import riscv_hwlp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_we_i,
    input  logic       end_we_i,
    input  logic       cnt_we_i,
    input  hwlp_word_t start_data_i,
    input  hwlp_word_t end_data_i,
    input  hwlp_word_t cnt_data_i,
    input  logic       dec_req_i,
    input  logic       fetch_advance_i,
    input  logic       id_valid_i,
    input  logic       flush_i,
    output hwlp_word_t start_addr_o,
    output hwlp_word_t end_addr_o,
    output hwlp_word_t counter_o,
    output logic       pending_o
);

    hwlp_word_t start_q, start_d;
    hwlp_word_t end_q, end_d;
    hwlp_word_t counter_q, counter_d;
    logic       pending_q, pending_d;

    // Next-state for registers and the in-flight tracker. The pending request
    // retires when the end-of-loop instruction leaves ID; a new request may
    // enter in that same cycle (back-to-back handoff).
    always_comb begin
        start_d   = start_q;
        end_d     = end_q;
        counter_d = counter_q;
        pending_d = pending_q;

        if (start_we_i) begin
            start_d = start_data_i;
        end
        if (end_we_i) begin
            end_d = end_data_i;
        end

        // A counter write overrides a decrement due in the same cycle.
        if (cnt_we_i) begin
            counter_d = cnt_data_i;
        end else if (id_valid_i && pending_q && !flush_i) begin
            counter_d = hwlp_sat_dec(counter_q);
        end

        if (flush_i) begin
            pending_d = 1'b0;
        end else if (id_valid_i && pending_q) begin
            pending_d = dec_req_i & fetch_advance_i;
        end else if (fetch_advance_i) begin
            pending_d = dec_req_i;
        end
    end

    // State registers; reset clears everything including any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= '0;
            end_q     <= '0;
            counter_q <= '0;
            pending_q <= 1'b0;
        end else begin
            start_q   <= start_d;
            end_q     <= end_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
        end
    end

    assign start_addr_o = start_q;
    assign end_addr_o   = end_q;
    assign counter_o    = counter_q;
    assign pending_o    = pending_q;

endmodule

// File: rtl/riscv_hwloop_regs_tracker.sv
// Register file and decrement tracker for the two hardware loops. Decodes the
// loop id into per-slot write enables and fans the pipeline controls out to
// each slot. All outputs come straight from registers.
module riscv_hwloop_regs_tracker
    import riscv_hwlp_pkg::*;
#(
    parameter int N_REGS    = HWLP_N_REGS,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] hwlp_start_data_i,
    input  logic [CNT_WIDTH-1:0] hwlp_end_data_i,
    input  logic [CNT_WIDTH-1:0] hwlp_cnt_data_i,
    input  logic [2:0]           hwlp_we_i,
    input  logic                 hwlp_regid_i,
    input  logic [N_REGS-1:0]    hwlp_dec_cnt_i,
    input  logic                 fetch_advance_i,
    input  logic                 id_valid_i,
    input  logic                 flush_i,
    output logic [CNT_WIDTH-1:0] hwlp_start_addr_0_o,
    output logic [CNT_WIDTH-1:0] hwlp_end_addr_0_o,
    output logic [CNT_WIDTH-1:0] hwlp_counter_0_o,
    output logic [CNT_WIDTH-1:0] hwlp_start_addr_1_o,
    output logic [CNT_WIDTH-1:0] hwlp_end_addr_1_o,
    output logic [CNT_WIDTH-1:0] hwlp_counter_1_o,
    output logic [N_REGS-1:0]    hwlp_dec_cnt_id_o
);

    hwlp_word_t start_addr [N_REGS];
    hwlp_word_t end_addr   [N_REGS];
    hwlp_word_t counter    [N_REGS];

    for (genvar g = 0; g < N_REGS; g++) begin : g_slot
        logic sel;
        assign sel = (hwlp_regid_i == 1'(g));

        riscv_hwloop_slot u_slot (
            .clk             (clk),
            .rst_n           (rst_n),
            .start_we_i      (hwlp_we_i[HWLP_WE_START] && sel),
            .end_we_i        (hwlp_we_i[HWLP_WE_END]   && sel),
            .cnt_we_i        (hwlp_we_i[HWLP_WE_CNT]   && sel),
            .start_data_i    (hwlp_start_data_i),
            .end_data_i      (hwlp_end_data_i),
            .cnt_data_i      (hwlp_cnt_data_i),
            .dec_req_i       (hwlp_dec_cnt_i[g]),
            .fetch_advance_i (fetch_advance_i),
            .id_valid_i      (id_valid_i),
            .flush_i         (flush_i),
            .start_addr_o    (start_addr[g]),
            .end_addr_o      (end_addr[g]),
            .counter_o       (counter[g]),
            .pending_o       (hwlp_dec_cnt_id_o[g])
        );
    end

    assign hwlp_start_addr_0_o = start_addr[0];
    assign hwlp_end_addr_0_o   = end_addr[0];
    assign hwlp_counter_0_o    = counter[0];
    assign hwlp_start_addr_1_o = start_addr[1];
    assign hwlp_end_addr_1_o   = end_addr[1];
    assign hwlp_counter_1_o    = counter[1];

endmodule
